mdio_phy_supervisor: RTL and testbench
======================================

Name: mdio_phy_supervisor

Overview:
Upstream command sequencer for the MDIO management engine. After reset it soft-resets the PHY, reads its ID, and enables and restarts auto-negotiation. It then polls link state at a fixed interval and publishes link-up, speed, duplex and a status-valid pulse to the MAC-side logic. It drives the engine's stb/is_write/phys_addr/reg_addr/i_data interface and consumes its stall/o_data.

Parameters:
PHY_ADDR, 5'd1, MDIO address of the attached PHY
POLL_INTERVAL, 2_500_000, i_clk cycles from the end of one poll round to the start of the next
RESET_POLL_GAP, 50_000, i_clk cycles between BMCR reset-bit polls
RESET_POLL_MAX, 16, maximum BMCR polls before declaring reset timeout
AN_CTRL, 16'h1200, BMCR value written to enable and restart auto-negotiation
AN_ADVERT, 16'h01E1, ANAR value written (10/100, half/full duplex, 802.3 selector)

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  synchronous reset, active low
i_restart_an  in  1  single-cycle request to rewrite ANAR/BMCR and restart auto-negotiation
mgmt_stb  out  1  transaction strobe to the management engine
mgmt_is_write  out  1  1=write, 0=read
mgmt_phys_addr  out  5  always PHY_ADDR
mgmt_reg_addr  out  5  register index
mgmt_wdata  out  16  write data
mgmt_stall  in  1  engine busy; accepts stb only when low
mgmt_rdata  in  16  engine read result; valid once stall falls after a read
phy_id1  out  16  PHYID1 (reg 2) contents
link_up  out  1  link status
an_complete  out  1  auto-negotiation complete
speed_100  out  1  1=100 Mb/s, 0=10 Mb/s
full_duplex  out  1  1=full duplex
status_valid  out  1  one-cycle pulse when a poll round updates the status outputs
phy_ready  out  1  init sequence finished; stays high
reset_timeout  out  1  sticky; BMCR bit 15 did not clear within RESET_POLL_MAX polls

Behaviour:
- Reset (i_reset_n low at a rising edge): all outputs 0, all counters 0, restart-pending flag cleared, FSM to S_RST_WR. Takes effect on that same edge even mid-transaction; mgmt_stb drops immediately.
- Transaction handshake, shared by every register access, via three sub-states:
  - ISSUE: mgmt_stb=1 for exactly one cycle, and only in a cycle where mgmt_stall=0.
  - WAIT_BUSY: wait for mgmt_stall=1. The engine raises stall the cycle after accepting stb.
  - WAIT_DONE: wait for mgmt_stall=0, then capture mgmt_rdata on that cycle for reads.
  - mgmt_is_write, mgmt_reg_addr and mgmt_wdata are held stable from ISSUE until WAIT_DONE exits.
  - If stall is already high on entry to ISSUE (engine busy after a reset of this block), hold off; stb is never asserted while stall=1.
- Main FSM:
  - S_RST_WR: write reg 0 = 16'h8000.
  - S_RST_GAP: count RESET_POLL_GAP cycles.
  - S_RST_RD: read reg 0. If bit 15 = 0, go to S_ID_RD. Else increment the poll count. When the count reaches RESET_POLL_MAX, set reset_timeout and go to S_ID_RD; otherwise return to S_RST_GAP.
  - S_ID_RD: read reg 2 and latch phy_id1.
  - S_ADV_WR: write reg 4 = AN_ADVERT.
  - S_AN_WR: write reg 0 = AN_CTRL, then set phy_ready and go to S_POLL_WAIT.
  - S_POLL_WAIT: count POLL_INTERVAL cycles. The count starts at 0 on entry; the first round after init starts immediately.
  - S_BMSR_A: read reg 1 and discard the result (clears the latched-low link bit).
  - S_BMSR_B: read reg 1; latch link = bit 2, ancomp = bit 5.
  - S_LPA_RD: read reg 5 as lpa.
  - S_UPDATE: one cycle. Set link_up = link, an_complete = ancomp. If link & ancomp, resolve c = lpa & AN_ADVERT by priority:
    - bit 8 -> 100 full
    - bit 7 -> 100 half
    - bit 6 -> 10 full
    - otherwise 10 half
  - S_UPDATE, continued: if !(link & ancomp), force speed_100 = 0 and full_duplex = 0. Pulse status_valid, then go to S_POLL_WAIT.
- i_restart_an: sets a pending flag in any state once phy_ready=1; ignored before phy_ready. The flag is checked only in S_POLL_WAIT: if set, clear it and go to S_ADV_WR. A request arriving mid-round is therefore serviced after that round's S_UPDATE. Multiple pulses collapse into one.
- Status outputs change only in S_UPDATE; they hold between rounds.
- Counters are 32 bits and saturate at the target; there is no wrap-around.

Decomposition:
- Package mdio_pkg:
  - register indices REG_BMCR=0, REG_BMSR=1, REG_PHYID1=2, REG_ANAR=4, REG_ANLPAR=5
  - bit positions BMCR_RESET=15, BMSR_LINK=2, BMSR_ANCOMP=5, LPA_100FD=8, LPA_100HD=7, LPA_10FD=6
  - main-state enum; transaction sub-state enum
- Sub-module mdio_txn: owns the ISSUE/WAIT_BUSY/WAIT_DONE handshake. Ports: req, is_write, reg_addr, wdata, done pulse, rdata, plus the mgmt_* signals. The supervisor FSM issues req and advances on done.

Test Plan:
- Init: PHY model returns reg0 = 8000, then 0000 on the second poll, and reg2 = 0022. Expected transactions in order: W0=8000, R0, R0, R2, W4=01E1, W0=1200. Then phy_id1=16'h0022, phy_ready=1, reset_timeout=0, and stb is never high while stall=1.
- Reset timeout: reg0 always returns 8000. Exactly 16 reg0 reads occur, reset_timeout=1, and the sequence continues to R2, W4, W0.
- Link 100FD: BMSR = 0024 on both reads, ANLPAR = 41E1. At status_valid: link_up=1, an_complete=1, speed_100=1, full_duplex=1. The next round starts POLL_INTERVAL cycles later.
- Link 10HD / link down: ANLPAR = 0021 gives speed_100=0, full_duplex=0 with link_up=1. Then BMSR = 0000 gives link_up=0 and speed/duplex forced to 0.
- Restart during poll: pulse i_restart_an during S_BMSR_B. The current round completes and status_valid pulses. Then exactly one W4=01E1, W0=1200 pair occurs, followed by a poll wait.
- Reset mid-transaction: drop i_reset_n while in WAIT_BUSY with the engine model holding stall high for 200 cycles. All outputs read 0 next cycle. After release, the first stb is delayed until stall falls, and it is W0=8000.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared definitions for the PHY supervisor: clause-22 register map, bit positions and FSM encodings.
package mdio_pkg;
  localparam logic [4:0] REG_BMCR   = 5'd0;
  localparam logic [4:0] REG_BMSR   = 5'd1;
  localparam logic [4:0] REG_PHYID1 = 5'd2;
  localparam logic [4:0] REG_ANAR   = 5'd4;
  localparam logic [4:0] REG_ANLPAR = 5'd5;

  localparam int BMCR_RESET  = 15;
  localparam int BMSR_LINK   = 2;
  localparam int BMSR_ANCOMP = 5;
  localparam int LPA_100FD   = 8;
  localparam int LPA_100HD   = 7;
  localparam int LPA_10FD    = 6;

  localparam logic [15:0] MASK_100FD = 16'd1 << LPA_100FD;
  localparam logic [15:0] MASK_100HD = 16'd1 << LPA_100HD;
  localparam logic [15:0] MASK_10FD  = 16'd1 << LPA_10FD;

  typedef enum logic [3:0] {
    S_RST_WR, S_RST_GAP, S_RST_RD, S_ID_RD, S_ADV_WR, S_AN_WR,
    S_POLL_WAIT, S_BMSR_A, S_BMSR_B, S_LPA_RD, S_UPDATE
  } main_state_t;

  typedef enum logic [1:0] {T_IDLE, T_ISSUE, T_WAIT_BUSY, T_WAIT_DONE} txn_state_t;
endpackage

// File: rtl/mdio_txn.sv
// One management-engine register access: strobe, wait for the engine to go busy, wait for it to finish.
module mdio_txn import mdio_pkg::*; #(
  parameter logic [4:0] PHY_ADDR = 5'd1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        req,
  input  logic        is_write,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wdata,
  output logic        done,
  output logic [15:0] rdata,
  output logic        mgmt_stb,
  output logic        mgmt_is_write,
  output logic [4:0]  mgmt_phys_addr,
  output logic [4:0]  mgmt_reg_addr,
  output logic [15:0] mgmt_wdata,
  input  logic        mgmt_stall,
  input  logic [15:0] mgmt_rdata
);
  txn_state_t state;

  // Gated by stall directly so a strobe can never coincide with a busy engine.
  assign mgmt_stb = (state == T_ISSUE) && !mgmt_stall;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state          <= T_IDLE;
      done           <= 1'b0;
      rdata          <= 16'h0;
      mgmt_is_write  <= 1'b0;
      mgmt_phys_addr <= 5'd0;
      mgmt_reg_addr  <= 5'd0;
      mgmt_wdata     <= 16'h0;
    end else begin
      done           <= 1'b0;
      mgmt_phys_addr <= PHY_ADDR;
      case (state)
        T_IDLE: if (req) begin
          mgmt_is_write <= is_write;
          mgmt_reg_addr <= reg_addr;
          mgmt_wdata    <= wdata;
          state         <= T_ISSUE;
        end
        T_ISSUE:     if (!mgmt_stall) state <= T_WAIT_BUSY;
        T_WAIT_BUSY: if (mgmt_stall)  state <= T_WAIT_DONE;
        T_WAIT_DONE: if (!mgmt_stall) begin
          if (!mgmt_is_write) rdata <= mgmt_rdata;
          done  <= 1'b1;
          state <= T_IDLE;
        end
        default: state <= T_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/mdio_phy_supervisor.sv
// PHY bring-up (reset, ID, auto-negotiation) followed by periodic link polling for the MAC side.
module mdio_phy_supervisor import mdio_pkg::*; #(
  parameter logic [4:0]  PHY_ADDR       = 5'd1,
  parameter int unsigned POLL_INTERVAL  = 2_500_000,
  parameter int unsigned RESET_POLL_GAP = 50_000,
  parameter int unsigned RESET_POLL_MAX = 16,
  parameter logic [15:0] AN_CTRL        = 16'h1200,
  parameter logic [15:0] AN_ADVERT      = 16'h01E1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_restart_an,
  output logic        mgmt_stb,
  output logic        mgmt_is_write,
  output logic [4:0]  mgmt_phys_addr,
  output logic [4:0]  mgmt_reg_addr,
  output logic [15:0] mgmt_wdata,
  input  logic        mgmt_stall,
  input  logic [15:0] mgmt_rdata,
  output logic [15:0] phy_id1,
  output logic        link_up,
  output logic        an_complete,
  output logic        speed_100,
  output logic        full_duplex,
  output logic        status_valid,
  output logic        phy_ready,
  output logic        reset_timeout
);
  main_state_t state;
  logic [31:0] wait_cnt, poll_cnt;
  logic        req, pend, done, skip_wait, restart_pend, link, ancomp;
  logic [15:0] rdata, lpa;
  logic        acc, acc_write;
  logic [4:0]  acc_reg;
  logic [15:0] acc_wdata;

  // {speed_100, full_duplex} from the common abilities, best mode first.
  function automatic logic [1:0] resolve_mode(input logic [15:0] lpa_v);
    logic [15:0] c;
    c = lpa_v & AN_ADVERT;
    if (|(c & MASK_100FD))      return 2'b11;
    else if (|(c & MASK_100HD)) return 2'b10;
    else if (|(c & MASK_10FD))  return 2'b01;
    else                        return 2'b00;
  endfunction

  always_comb begin
    acc = 1'b0; acc_write = 1'b0; acc_reg = REG_BMCR; acc_wdata = 16'h0;
    case (state)
      S_RST_WR: begin acc = 1'b1; acc_write = 1'b1; acc_wdata = 16'h8000; end
      S_RST_RD: acc = 1'b1;
      S_ID_RD:  begin acc = 1'b1; acc_reg = REG_PHYID1; end
      S_ADV_WR: begin acc = 1'b1; acc_write = 1'b1; acc_reg = REG_ANAR; acc_wdata = AN_ADVERT; end
      S_AN_WR:  begin acc = 1'b1; acc_write = 1'b1; acc_wdata = AN_CTRL; end
      S_BMSR_A, S_BMSR_B: begin acc = 1'b1; acc_reg = REG_BMSR; end
      S_LPA_RD: begin acc = 1'b1; acc_reg = REG_ANLPAR; end
      default: ;
    endcase
  end

  mdio_txn #(.PHY_ADDR(PHY_ADDR)) u_txn (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .req(req), .is_write(acc_write), .reg_addr(acc_reg), .wdata(acc_wdata),
    .done(done), .rdata(rdata),
    .mgmt_stb(mgmt_stb), .mgmt_is_write(mgmt_is_write), .mgmt_phys_addr(mgmt_phys_addr),
    .mgmt_reg_addr(mgmt_reg_addr), .mgmt_wdata(mgmt_wdata),
    .mgmt_stall(mgmt_stall), .mgmt_rdata(mgmt_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= S_RST_WR;
      req <= 1'b0; pend <= 1'b0; skip_wait <= 1'b0; restart_pend <= 1'b0;
      wait_cnt <= 32'd0; poll_cnt <= 32'd0;
      link <= 1'b0; ancomp <= 1'b0; lpa <= 16'h0; phy_id1 <= 16'h0;
      link_up <= 1'b0; an_complete <= 1'b0; speed_100 <= 1'b0; full_duplex <= 1'b0;
      status_valid <= 1'b0; phy_ready <= 1'b0; reset_timeout <= 1'b0;
    end else begin
      req          <= 1'b0;
      status_valid <= 1'b0;
      if (i_restart_an && phy_ready) restart_pend <= 1'b1;
      // Access fields come from the state, which cannot move until done returns.
      if (acc && !pend) begin
        req  <= 1'b1;
        pend <= 1'b1;
      end
      if (done) pend <= 1'b0;
      case (state)
        S_RST_WR: if (done) state <= S_RST_GAP;
        S_RST_GAP:
          if (wait_cnt + 32'd1 >= RESET_POLL_GAP) begin
            wait_cnt <= 32'd0;
            state    <= S_RST_RD;
          end else wait_cnt <= wait_cnt + 32'd1;
        S_RST_RD: if (done) begin
          if (!rdata[BMCR_RESET]) state <= S_ID_RD;
          else if (poll_cnt + 32'd1 >= RESET_POLL_MAX) begin
            poll_cnt      <= RESET_POLL_MAX;
            reset_timeout <= 1'b1;
            state         <= S_ID_RD;
          end else begin
            poll_cnt <= poll_cnt + 32'd1;
            state    <= S_RST_GAP;
          end
        end
        S_ID_RD:  if (done) begin phy_id1 <= rdata; state <= S_ADV_WR; end
        S_ADV_WR: if (done) state <= S_AN_WR;
        S_AN_WR: if (done) begin
          phy_ready <= 1'b1;
          skip_wait <= !phy_ready;  // only the very first round skips the interval
          wait_cnt  <= 32'd0;
          state     <= S_POLL_WAIT;
        end
        S_POLL_WAIT:
          if (restart_pend) begin
            restart_pend <= 1'b0;
            wait_cnt     <= 32'd0;
            state        <= S_ADV_WR;
          end else if (skip_wait || (wait_cnt + 32'd1 >= POLL_INTERVAL)) begin
            skip_wait <= 1'b0;
            wait_cnt  <= 32'd0;
            state     <= S_BMSR_A;
          end else wait_cnt <= wait_cnt + 32'd1;
        S_BMSR_A: if (done) state <= S_BMSR_B;
        S_BMSR_B: if (done) begin
          link   <= rdata[BMSR_LINK];
          ancomp <= rdata[BMSR_ANCOMP];
          state  <= S_LPA_RD;
        end
        S_LPA_RD: if (done) begin lpa <= rdata; state <= S_UPDATE; end
        S_UPDATE: begin
          link_up     <= link;
          an_complete <= ancomp;
          if (link && ancomp) {speed_100, full_duplex} <= resolve_mode(lpa);
          else                {speed_100, full_duplex} <= 2'b00;
          status_valid <= 1'b1;
          wait_cnt     <= 32'd0;
          state        <= S_POLL_WAIT;
        end
        default: state <= S_RST_WR;
      endcase
    end
  end
endmodule

// File: tb/tb_mdio_phy_supervisor.sv
// Directed bench: a management-engine/PHY model logs every accepted access and answers reads from small tables.
module tb_mdio_phy_supervisor;
  localparam int POLL = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart_an = 1'b0;
  logic        stb, is_write, stall = 1'b0;
  logic [4:0]  phys_addr, reg_addr;
  logic [15:0] wdata, rdata = 16'h0;
  logic [15:0] phy_id1;
  logic        link_up, an_complete, speed_100, full_duplex, status_valid, phy_ready, reset_timeout;

  mdio_phy_supervisor #(
    .PHY_ADDR(5'd1), .POLL_INTERVAL(POLL), .RESET_POLL_GAP(10), .RESET_POLL_MAX(16),
    .AN_CTRL(16'h1200), .AN_ADVERT(16'h01E1)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_restart_an(restart_an),
    .mgmt_stb(stb), .mgmt_is_write(is_write), .mgmt_phys_addr(phys_addr),
    .mgmt_reg_addr(reg_addr), .mgmt_wdata(wdata), .mgmt_stall(stall), .mgmt_rdata(rdata),
    .phy_id1(phy_id1), .link_up(link_up), .an_complete(an_complete), .speed_100(speed_100),
    .full_duplex(full_duplex), .status_valid(status_valid), .phy_ready(phy_ready),
    .reset_timeout(reset_timeout)
  );

  always #5 clk = ~clk;

  // Engine / PHY model
  logic [21:0] tx_log [0:255];
  logic [4:0]  tx_phys [0:255];
  int          tx_n = 0;
  int          busy_cnt = 0;
  int          r0_reads = 0;
  int          r0_base = 0;
  int          clear_after = 1;
  logic        hold_next = 1'b0;
  logic [15:0] bmsr_val = 16'h0024;
  logic [15:0] lpa_val = 16'h41E1;
  logic [15:0] resp = 16'h0;
  int          viol = 0;

  always @(posedge clk) begin
    if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) begin
        stall <= 1'b0;
        rdata <= resp;
      end
    end else if (stb && !stall) begin
      tx_log[tx_n[7:0]]  <= {is_write, reg_addr, is_write ? wdata : 16'h0};
      tx_phys[tx_n[7:0]] <= phys_addr;
      tx_n     <= tx_n + 1;
      stall    <= 1'b1;
      busy_cnt <= hold_next ? 200 : 3;
      case (reg_addr)
        5'd0: resp <= ((r0_reads - r0_base) < clear_after) ? 16'h8000 : 16'h0000;
        5'd1: resp <= bmsr_val;
        5'd2: resp <= 16'h0022;
        5'd5: resp <= lpa_val;
        default: resp <= 16'h0;
      endcase
      if (!is_write && reg_addr == 5'd0) r0_reads <= r0_reads + 1;
    end
  end

  always @(negedge clk) if (stb && stall) viol <= viol + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] enc(input logic w, input logic [4:0] r, input logic [15:0] d);
    return {w, r, d};
  endfunction

  task automatic wait_tx(input string tag, input int n, input int bound);
    for (int k = 0; k < bound; k++) begin
      if (tx_n >= n) break;
      @(negedge clk);
    end
    check(tag, tx_n, n);
  endtask

  task automatic wait_sv(input string tag);
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      if (status_valid) break;
    end
    check(tag, status_valid, 1);
  endtask

  task automatic wait_ready(input string tag, input int bound);
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (phy_ready) break;
    end
    check(tag, phy_ready, 1);
  endtask

  logic [21:0] init_exp [0:5];
  logic [15:0] lpa_t [0:3];
  logic [15:0] bmsr_t [0:3];
  logic [3:0]  stat_t [0:3];

  initial begin
    int g, idx, n1, r0c;
    init_exp[0] = enc(1'b1, 5'd0, 16'h8000);
    init_exp[1] = enc(1'b0, 5'd0, 16'h0);
    init_exp[2] = enc(1'b0, 5'd0, 16'h0);
    init_exp[3] = enc(1'b0, 5'd2, 16'h0);
    init_exp[4] = enc(1'b1, 5'd4, 16'h01E1);
    init_exp[5] = enc(1'b1, 5'd0, 16'h1200);
    lpa_t[0] = 16'h0021; bmsr_t[0] = 16'h0024; stat_t[0] = 4'b1100;
    lpa_t[1] = 16'h00A1; bmsr_t[1] = 16'h0024; stat_t[1] = 4'b1110;
    lpa_t[2] = 16'h0041; bmsr_t[2] = 16'h0024; stat_t[2] = 4'b1101;
    lpa_t[3] = 16'h41E1; bmsr_t[3] = 16'h0000; stat_t[3] = 4'b0000;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mgmt", {stb, is_write, phys_addr, reg_addr, wdata}, 0);
    check("rst_status", {phy_id1, link_up, an_complete, speed_100, full_duplex,
                         status_valid, phy_ready, reset_timeout}, 0);
    rst_n = 1'b1;

    // Init sequence: reset bit clears on the second poll
    wait_ready("init_ready", 2000);
    check("init_txn_count", tx_n, 6);
    for (int i = 0; i < 6; i++) check($sformatf("init_txn%0d", i), tx_log[i], init_exp[i]);
    check("init_phys", tx_phys[0], 5'd1);
    check("init_id", phy_id1, 16'h0022);
    check("init_timeout", reset_timeout, 0);

    // First round runs immediately: 100FD
    wait_sv("sv_100fd");
    check("stat_100fd", {link_up, an_complete, speed_100, full_duplex}, 4'b1111);
    check("round_txns", {tx_log[6], tx_log[7], tx_log[8]},
          {enc(1'b0, 5'd1, 16'h0), enc(1'b0, 5'd1, 16'h0), enc(1'b0, 5'd5, 16'h0)});
    lpa_val = lpa_t[0]; bmsr_val = bmsr_t[0];
    g = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      g++;
      if (g == 1) check("sv_pulse_width", status_valid, 0);
      if (stb) break;
    end
    check("poll_gap", g, POLL + 2);

    // 10HD, 100HD, 10FD, then link down with forced speed/duplex
    for (int i = 0; i < 4; i++) begin
      wait_sv($sformatf("sv_tab%0d", i));
      check($sformatf("stat_tab%0d", i), {link_up, an_complete, speed_100, full_duplex}, stat_t[i]);
      if (i < 3) begin lpa_val = lpa_t[i + 1]; bmsr_val = bmsr_t[i + 1]; end
    end
    bmsr_val = 16'h0024; lpa_val = 16'h41E1;

    // Restart requested while the second BMSR read is in flight
    n1 = 0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      if (stb && reg_addr == 5'd1) n1++;
      if (n1 == 2) break;
    end
    check("restart_at_bmsr_b", n1, 2);
    restart_an = 1'b1; @(negedge clk); restart_an = 1'b0;
    repeat (3) @(negedge clk);
    restart_an = 1'b1; @(negedge clk); restart_an = 1'b0;
    wait_sv("restart_round_sv");
    idx = tx_n;
    wait_tx("restart_pair", idx + 2, 100);
    check("restart_w4", tx_log[idx[7:0]], enc(1'b1, 5'd4, 16'h01E1));
    check("restart_w0", tx_log[8'(idx + 1)], enc(1'b1, 5'd0, 16'h1200));
    repeat (150) @(negedge clk);
    check("restart_single_pair", tx_n, idx + 2);
    wait_tx("restart_next_poll", idx + 3, 200);
    check("restart_then_r1", tx_log[8'(idx + 2)], enc(1'b0, 5'd1, 16'h0));

    // Reset while the engine holds stall; then reset bit never clears
    hold_next = 1'b1;
    wait_tx("hold_accept", idx + 4, 400);
    hold_next = 1'b0;
    r0_base = r0_reads;
    clear_after = 1000;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_stall_held", stall, 1);
    check("midrst_mgmt", {stb, is_write, phys_addr, reg_addr, wdata}, 0);
    check("midrst_status", {phy_id1, link_up, an_complete, speed_100, full_duplex,
                            status_valid, phy_ready, reset_timeout}, 0);
    rst_n = 1'b1;
    idx = tx_n;
    g = 0;
    for (int k = 0; k < 400; k++) begin
      if (tx_n > idx) break;
      @(negedge clk);
      g++;
    end
    check("midrst_first_txn", tx_n, idx + 1);
    check("midrst_delayed", g > 190, 1);
    check("midrst_w0", tx_log[idx[7:0]], enc(1'b1, 5'd0, 16'h8000));
    wait_ready("timeout_ready", 3000);
    r0c = 0;
    for (int i = idx + 1; i < tx_n; i++) if (tx_log[8'(i)] == enc(1'b0, 5'd0, 16'h0)) r0c++;
    check("timeout_r0_count", r0c, 16);
    check("timeout_txn_count", tx_n, idx + 20);
    check("timeout_flag", reset_timeout, 1);
    check("timeout_tail", {tx_log[8'(idx + 17)], tx_log[8'(idx + 18)], tx_log[8'(idx + 19)]},
          {enc(1'b0, 5'd2, 16'h0), enc(1'b1, 5'd4, 16'h01E1), enc(1'b1, 5'd0, 16'h1200)});
    check("stb_vs_stall", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
